// File: rtl/sat_window_accumulator_pkg.sv
// Shared state encoding and clamp helper for the windowed saturating accumulator.
package sat_window_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Largest unsigned value representable in w bits.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_window_accumulator_sat_add.sv
// Combinational unsigned adder that clamps to the all-ones value of the S_W-bit result.
module sat_add_n
  import sat_window_accumulator_pkg::*;
#(
  parameter int A_W = 6,
  parameter int B_W = 4,
  parameter int S_W = 6
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [S_W-1:0] sum_o,
  output logic           clamped_o
);

  localparam int AB_W  = (A_W > B_W) ? A_W : B_W;
  localparam int SUM_W = ((AB_W > S_W) ? AB_W : S_W) + 1;
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(sat_max(S_W));

  // One spare bit guarantees the raw sum never wraps before the compare.
  logic [SUM_W-1:0] full_sum;

  always_comb begin
    full_sum  = SUM_W'(a_i) + SUM_W'(b_i);
    clamped_o = (full_sum > MAX_V);
    sum_o     = clamped_o ? '1 : full_sum[S_W-1:0];
  end

endmodule

// File: rtl/sat_window_accumulator.sv
// Accumulates WINDOW accepted samples with saturation and presents the total on a
// valid/ready output, flagging any clamp that occurred inside the window.
module sat_window_accumulator
  import sat_window_accumulator_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int ACC_W  = 6,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;
  logic             sat_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic             out_sat_q;

  logic [ACC_W-1:0] acc_d;
  logic             clamp_now;
  logic [7:0]       cnt_d;
  logic             sat_d;
  logic             accept;
  logic             last_sample;

  sat_add_n #(
    .A_W (ACC_W),
    .B_W (IN_W),
    .S_W (ACC_W)
  ) u_add (
    .a_i       (acc_q),
    .b_i       (in_data),
    .sum_o     (acc_d),
    .clamped_o (clamp_now)
  );

  always_comb begin
    in_ready    = (state_q != ST_HOLD);
    busy        = (state_q != ST_IDLE);
    accept      = in_valid & in_ready;
    cnt_d       = cnt_q + 8'd1;
    sat_d       = sat_q | clamp_now;
    // cnt_q is zero in IDLE, so this also covers a one-sample window.
    last_sample = (cnt_d == 8'(WINDOW));
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (last_sample) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              out_sat_q   <= sat_d;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          // Result stays frozen until the sink takes it; no new window overlaps.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_window_accumulator.sv
// Directed bench for sat_window_accumulator: an 8-sample window instance plus a
// one-sample window instance sharing clock and reset.
module tb_sat_window_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       out_sat;
  logic       busy;

  logic       w1_clear;
  logic       w1_in_valid;
  logic       w1_in_ready;
  logic [3:0] w1_in_data;
  logic       w1_out_valid;
  logic       w1_out_ready;
  logic [5:0] w1_out_data;
  logic       w1_out_sat;
  logic       w1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_window_accumulator #(.IN_W(4), .ACC_W(6), .WINDOW(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  sat_window_accumulator #(.IN_W(4), .ACC_W(6), .WINDOW(1)) u_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w1_clear),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .in_data   (w1_in_data),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_data  (w1_out_data),
    .out_sat   (w1_out_sat),
    .busy      (w1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_busy", busy, 0);
  endtask

  task automatic w1_push(input logic [3:0] v);
    w1_in_valid = 1'b1;
    w1_in_data  = v;
    step();
    w1_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 4'd7; out_ready = 1'b0;
    w1_clear = 1'b0; w1_in_valid = 1'b1; w1_in_data = 4'd7; w1_out_ready = 1'b0;

    // 1. reset with in_valid held high
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_w1_out_valid", w1_out_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0; w1_in_valid = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    // 2. eight samples of 5
    for (int i = 0; i < 7; i++) push(4'd5);
    chk("sum5_pre_valid", out_valid, 0);
    chk("sum5_pre_busy", busy, 1);
    push(4'd5);
    chk("sum5_valid", out_valid, 1);
    chk("sum5_data", out_data, 40);
    chk("sum5_sat", out_sat, 0);
    chk("sum5_busy", busy, 1);
    chk("sum5_in_ready", in_ready, 0);
    release_result();

    // 3. eight samples of 15 clamp at 63
    for (int i = 0; i < 4; i++) push(4'd15);
    chk("sum15_mid_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) push(4'd15);
    chk("sum15_valid", out_valid, 1);
    chk("sum15_data", out_data, 63);
    chk("sum15_sat", out_sat, 1);

    // 4. backpressure with in_valid high; samples must be ignored
    in_valid = 1'b1; in_data = 4'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data", out_data, 63);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_busy", busy, 0);
    chk("bp_rel_in_ready", in_ready, 1);
    push(4'd9);
    chk("bp_first_busy", busy, 1);
    for (int i = 0; i < 7; i++) push(4'd1);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 16);
    chk("bp_next_sat", out_sat, 0);
    release_result();

    // 5. stalls between samples
    push(4'd3); idle(2);
    chk("stall_busy", busy, 1);
    chk("stall_valid", out_valid, 0);
    push(4'd0); idle(1);
    push(4'd4); idle(3);
    for (int i = 0; i < 4; i++) push(4'd1);
    chk("stall_pre_valid", out_valid, 0);
    push(4'd1);
    chk("stall_valid_end", out_valid, 1);
    chk("stall_data", out_data, 12);
    chk("stall_sat", out_sat, 0);
    release_result();

    // 6. clear mid-window (with a sample offered in the same cycle)
    for (int i = 0; i < 4; i++) push(4'd15);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd15;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) push(4'd2);
    chk("clear_valid_end", out_valid, 1);
    chk("clear_data", out_data, 16);
    chk("clear_sat", out_sat, 0);
    release_result();

    // 7. reaching exactly 63 and adding zeros is not a clamp
    for (int i = 0; i < 4; i++) push(4'd15);
    push(4'd3);
    for (int i = 0; i < 3; i++) push(4'd0);
    chk("exact_valid", out_valid, 1);
    chk("exact_data", out_data, 63);
    chk("exact_sat", out_sat, 0);
    release_result();

    // 8. one-sample window: each accept is its own result
    w1_push(4'd7);
    chk("w1_a_valid", w1_out_valid, 1);
    chk("w1_a_data", w1_out_data, 7);
    chk("w1_a_in_ready", w1_in_ready, 0);
    w1_in_valid = 1'b1; w1_in_data = 4'd2;
    step();
    chk("w1_hold_data", w1_out_data, 7);
    w1_in_valid = 1'b0;
    w1_out_ready = 1'b1;
    step();
    w1_out_ready = 1'b0;
    chk("w1_rel_valid", w1_out_valid, 0);
    chk("w1_rel_busy", w1_busy, 0);
    w1_push(4'd15);
    chk("w1_b_valid", w1_out_valid, 1);
    chk("w1_b_data", w1_out_data, 15);
    chk("w1_b_sat", w1_out_sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
